// File: rtl/sp_ram_pkg.sv
// Shared types and width helpers for the sp_ram controller front-end.
//   state_e   : controller state (S_CLEAR sweeps memory to zero, S_RUN serves requests)
//   cnt_width : bits needed to hold a count in 0..max_val
//   ptr_width : bits needed to index depth entries
package sp_ram_pkg;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/sp_ram_rsp_fifo.sv
// Synchronous response FIFO holding read data until the consumer takes it.
//   clk, rst    : clock, asynchronous active-high reset
//   push, din   : write din when push (ignored while full)
//   pop, dout   : dout shows the oldest entry; pop removes it (ignored while empty)
//   full, empty : occupancy flags
module sp_ram_rsp_fifo
  import sp_ram_pkg::*;
#(
  parameter int unsigned DW    = 18,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    full     = (cnt_q == CW'(DEPTH));
    empty    = (cnt_q == '0);
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_ok ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok && !pop_ok) begin
      cnt_d = cnt_q + CW'(1);
    end else if (pop_ok && !push_ok) begin
      cnt_d = cnt_q - CW'(1);
    end
    dout = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Data storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/sp_ram_ctrl.sv
// Initiator-side front-end for a single-port RAM with LATENCY-cycle reads.
//   clk, rst                          : clock, asynchronous active-high reset
//   req_valid/req_ready/req_we/
//   req_addr/req_wdata                : request stream (reads and writes)
//   rsp_valid/rsp_ready/rsp_data      : read-data stream, in request order
//   init_done                         : high once the optional zero-sweep has finished
//   ram_we/ram_addr/ram_din/ram_dout  : port of the attached RAM
// Reads consume a credit until their data is popped, so the response FIFO never overflows.
module sp_ram_ctrl
  import sp_ram_pkg::*;
#(
  parameter int unsigned AW             = 10,
  parameter int unsigned DW             = 18,
  parameter int unsigned LATENCY        = 2,
  parameter int unsigned RSP_DEPTH      = 4,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          init_done,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  localparam int unsigned CW = cnt_width(RSP_DEPTH);
  localparam state_e RESET_STATE = CLEAR_ON_RESET ? S_CLEAR : S_RUN;

  state_e             state_q, state_d;
  logic [AW-1:0]      clr_cnt_q, clr_cnt_d;
  logic               init_done_q, init_done_d;
  logic [CW-1:0]      credits_q, credits_d;
  logic [LATENCY-1:0] tag_q, tag_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [DW-1:0]      din_q, din_d;

  logic clearing;
  logic req_fire, rd_fire, rsp_fire;
  logic fifo_push, fifo_full, fifo_empty;

  always_comb begin
    // Gate the sweep with rst so the RAM port sits idle while reset is held.
    clearing  = (state_q == S_CLEAR) && !rst;
    // Writes never need a credit; reads wait for a free response slot.
    req_ready = init_done_q && (req_we || (credits_q < CW'(RSP_DEPTH)));
    req_fire  = req_valid && req_ready;
    rd_fire   = req_fire && !req_we;
    rsp_fire  = rsp_valid && rsp_ready;

    ram_we   = 1'b0;
    ram_addr = addr_q;
    ram_din  = din_q;
    if (clearing) begin
      ram_we   = 1'b1;
      ram_addr = clr_cnt_q;
      ram_din  = '0;
    end else if (req_fire) begin
      ram_we   = req_we;
      ram_addr = req_addr;
      ram_din  = req_wdata;
    end
    addr_d = ram_addr;
    din_d  = ram_din;

    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (clearing) begin
      if (clr_cnt_q == '1) begin
        state_d = S_RUN;
      end else begin
        clr_cnt_d = clr_cnt_q + AW'(1);
      end
    end
    init_done_d = (state_d == S_RUN);

    credits_d = credits_q;
    if (rd_fire && !rsp_fire) begin
      credits_d = credits_q + CW'(1);
    end else if (rsp_fire && !rd_fire) begin
      credits_d = credits_q - CW'(1);
    end

    // Tag marks the cycle in which ram_dout carries this read's data.
    tag_d[0] = rd_fire;
    for (int i = 1; i < LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end
    fifo_push = tag_q[LATENCY-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RESET_STATE;
      clr_cnt_q   <= '0;
      init_done_q <= 1'b0;
      credits_q   <= '0;
      tag_q       <= '0;
      addr_q      <= '0;
      din_q       <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      init_done_q <= init_done_d;
      credits_q   <= credits_d;
      tag_q       <= tag_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
    end
  end

  assign init_done = init_done_q;
  assign rsp_valid = !fifo_empty;

  sp_ram_rsp_fifo #(
    .DW   (DW),
    .DEPTH(RSP_DEPTH)
  ) u_rsp_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fifo_push),
    .din  (ram_dout),
    .pop  (rsp_fire),
    .dout (rsp_data),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  rsp_overflow_a : assert property (@(posedge clk) disable iff (rst) !(fifo_push && fifo_full));

endmodule

// File: tb/tb_sp_ram_ctrl.sv
module tb_sp_ram_ctrl;

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 18;
  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned NW    = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic          init_done;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  sp_ram_ctrl #(
    .AW            (AW),
    .DW            (DW),
    .LATENCY       (LAT),
    .RSP_DEPTH     (DEPTH),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .init_done(init_done),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  always #5 clk = ~clk;

  // Single-port RAM stand-in: registered inputs, read-first, LAT-cycle read data.
  logic [DW-1:0] ram_m [NW];
  logic          we_r;
  logic [AW-1:0] a_r;
  logic [DW-1:0] d_r;
  logic [DW-1:0] dpipe [LAT-1];
  always @(posedge clk) begin
    we_r <= ram_we;
    a_r  <= ram_addr;
    d_r  <= ram_din;
    if (we_r) ram_m[a_r] <= d_r;
    dpipe[0] <= ram_m[a_r];
    for (int i = 1; i < int'(LAT) - 1; i++) dpipe[i] <= dpipe[i-1];
  end
  assign ram_dout = dpipe[LAT-2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Behavioural model: memory contents, queued read results with the cycle they become visible.
  logic [DW-1:0] mem_m [NW];
  logic [DW-1:0] exp_data_q[$];
  int            exp_time_q[$];
  int            outstanding = 0;
  int            clr_idx = 0;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_din = '0;
  logic          exp_rv, exp_rdy, acc;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_init_done", 32'(init_done), 0);
      chk("rst_ram_we", 32'(ram_we), 0);
      exp_data_q.delete();
      exp_time_q.delete();
      outstanding = 0;
      clr_idx     = 0;
      prev_addr   = '0;
      prev_din    = '0;
    end else if (clr_idx < int'(NW)) begin
      chk("clr_ram_we", 32'(ram_we), 1);
      chk("clr_ram_addr", 32'(ram_addr), 32'(clr_idx));
      chk("clr_ram_din", 32'(ram_din), 0);
      chk("clr_req_ready", 32'(req_ready), 0);
      chk("clr_rsp_valid", 32'(rsp_valid), 0);
      chk("clr_init_done", 32'(init_done), 0);
      mem_m[clr_idx] = '0;
      prev_addr = AW'(clr_idx);
      prev_din  = '0;
      clr_idx++;
    end else begin
      exp_rv  = (exp_data_q.size() > 0) && (exp_time_q[0] <= cyc);
      exp_rdy = req_we || (outstanding < int'(DEPTH));
      acc     = req_valid && exp_rdy;
      chk("init_done", 32'(init_done), 1);
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      if (exp_rv) chk("rsp_data", 32'(rsp_data), 32'(exp_data_q[0]));
      chk("ram_we", 32'(ram_we), 32'(acc && req_we));
      chk("ram_addr", 32'(ram_addr), 32'(acc ? req_addr : prev_addr));
      chk("ram_din", 32'(ram_din), 32'(acc ? req_wdata : prev_din));
      if (acc) begin
        prev_addr = req_addr;
        prev_din  = req_wdata;
      end
      if (exp_rv && rsp_ready) begin
        void'(exp_data_q.pop_front());
        void'(exp_time_q.pop_front());
        outstanding--;
      end
      if (acc && req_we) mem_m[req_addr] = req_wdata;
      if (acc && !req_we) begin
        exp_data_q.push_back(mem_m[req_addr]);
        exp_time_q.push_back(cyc + int'(LAT) + 1);
        outstanding++;
      end
    end
  end

  // Values sampled at the negedge of the last cycle driven by cyc_do.
  logic          s_rdy, s_rv, s_we, s_init;
  logic [DW-1:0] s_rdat;

  // Called at posedge+1: drives one cycle of inputs, samples outputs, returns at next posedge+1.
  task automatic cyc_do(input logic v, input logic we, input int a, input logic [DW-1:0] d,
                        input logic rr);
    req_valid = v;
    req_we    = we;
    req_addr  = a[AW-1:0];
    req_wdata = d;
    rsp_ready = rr;
    @(negedge clk);
    s_rdy  = req_ready;
    s_rv   = rsp_valid;
    s_we   = ram_we;
    s_init = init_done;
    s_rdat = rsp_data;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(output int lat, output logic [DW-1:0] data);
    lat  = -1;
    data = '0;
    for (int k = 1; k <= 12; k++) begin
      cyc_do(1'b0, 1'b0, 0, '0, 1'b1);
      if (s_rv) begin
        lat  = k;
        data = s_rdat;
        break;
      end
    end
  endtask

  task automatic wait_clear(output int n_we, output int n_stale);
    n_we    = 0;
    n_stale = 0;
    for (int k = 0; k < 40; k++) begin
      cyc_do(1'b0, 1'b0, 0, '0, 1'b1);
      if (s_rv) n_stale++;
      if (s_init) break;
      if (s_we) n_we++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

  initial begin
    int            n, stale, lat, acc_n, got, pend, drops, bad, win;
    logic [DW-1:0] data;
    logic [DW-1:0] wv [NW];
    logic [DW-1:0] edge_d [2];

    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Clear sweep after reset, then a cleared word reads back as zero.
    wait_clear(n, stale);
    chk("clear_len", 32'(n), 32'(NW));
    chk("clear_init_done", 32'(s_init), 1);
    cyc_do(1'b1, 1'b0, 7, '0, 1'b1);
    chk("rd7_accept", 32'(s_rdy), 1);
    wait_rsp(lat, data);
    chk("rd7_latency", 32'(lat), 3);
    chk("rd7_data", 32'(data), 0);

    // Write followed immediately by a read of the same address.
    cyc_do(1'b1, 1'b1, 3, 18'h155, 1'b1);
    cyc_do(1'b1, 1'b0, 3, '0, 1'b1);
    wait_rsp(lat, data);
    chk("raw_latency", 32'(lat), 3);
    chk("raw_data", 32'(data), 32'h155);

    // Backpressure: only DEPTH reads fit while the consumer stalls; writes still flow.
    for (int i = 0; i < 6; i++) cyc_do(1'b1, 1'b1, i, DW'(32'h100 + i), 1'b1);
    acc_n = 0;
    for (int i = 0; i < 6; i++) begin
      cyc_do(1'b1, 1'b0, i, '0, 1'b0);
      if (s_rdy) acc_n++;
    end
    chk("bp_accepted", 32'(acc_n), 4);
    cyc_do(1'b1, 1'b0, 5, '0, 1'b0);
    chk("bp_read_blocked", 32'(s_rdy), 0);
    cyc_do(1'b1, 1'b1, 9, 18'h2aa, 1'b0);
    chk("bp_write_accepted", 32'(s_rdy), 1);
    got  = 0;
    pend = 0;
    for (int k = 0; k < 20 && got < 6; k++) begin
      cyc_do(pend < 2, 1'b0, 4 + pend, '0, 1'b1);
      if (pend < 2 && s_rdy) pend++;
      if (s_rv) begin
        chk("bp_order", 32'(s_rdat), 32'h100 + 32'(got));
        got++;
      end
    end
    chk("bp_late_reads", 32'(pend), 2);
    chk("bp_responses", 32'(got), 6);

    // Streaming: back-to-back reads with the consumer always ready.
    for (int i = 0; i < int'(NW); i++) begin
      wv[i] = DW'($urandom);
      cyc_do(1'b1, 1'b1, i, wv[i], 1'b1);
    end
    drops = 0;
    got   = 0;
    bad   = 0;
    for (int i = 0; i < 64; i++) begin
      cyc_do(1'b1, 1'b0, i % int'(NW), '0, 1'b1);
      if (!s_rdy) drops++;
      if (s_rv) begin
        if (s_rdat !== wv[got % int'(NW)]) bad++;
        got++;
      end
    end
    win = got;
    for (int k = 0; k < 10; k++) begin
      cyc_do(1'b0, 1'b0, 0, '0, 1'b1);
      if (s_rv) begin
        if (s_rdat !== wv[got % int'(NW)]) bad++;
        got++;
      end
    end
    chk("stream_ready_drops", 32'(drops), 0);
    chk("stream_in_window", 32'(win), 32'(64 - int'(LAT) - 1));
    chk("stream_total", 32'(got), 64);
    chk("stream_bad_data", 32'(bad), 0);

    // Top and bottom addresses back-to-back.
    cyc_do(1'b1, 1'b1, int'(NW) - 1, 18'h3ffff, 1'b1);
    cyc_do(1'b1, 1'b1, 0, 18'h00001, 1'b1);
    cyc_do(1'b1, 1'b0, int'(NW) - 1, '0, 1'b1);
    cyc_do(1'b1, 1'b0, 0, '0, 1'b1);
    got = 0;
    for (int k = 0; k < 10 && got < 2; k++) begin
      cyc_do(1'b0, 1'b0, 0, '0, 1'b1);
      if (s_rv) begin
        edge_d[got] = s_rdat;
        got++;
      end
    end
    chk("edge_count", 32'(got), 2);
    chk("edge_top", 32'(edge_d[0]), 32'h3ffff);
    chk("edge_zero", 32'(edge_d[1]), 32'h1);

    // Random traffic, checked cycle by cycle against the model.
    for (int k = 0; k < 400; k++) begin
      cyc_do($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), int'($urandom_range(0, NW - 1)),
             DW'($urandom), $urandom_range(0, 9) < 7);
    end

    // Reset with reads in flight.
    for (int k = 0; k < 12; k++) cyc_do(1'b0, 1'b0, 0, '0, 1'b1);
    for (int i = 1; i <= 3; i++) cyc_do(1'b1, 1'b0, i, '0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 0);
    chk("midrst_req_ready", 32'(req_ready), 0);
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_clear(n, stale);
    chk("midrst_clear_len", 32'(n), 32'(NW));
    chk("midrst_stale_in_clear", 32'(stale), 0);
    cyc_do(1'b1, 1'b0, 3, '0, 1'b1);
    wait_rsp(lat, data);
    chk("midrst_rd_latency", 32'(lat), 3);
    chk("midrst_rd_data", 32'(data), 0);
    stale = 0;
    for (int k = 0; k < 6; k++) begin
      cyc_do(1'b0, 1'b0, 0, '0, 1'b1);
      if (s_rv) stale++;
    end
    chk("midrst_no_extra_rsp", 32'(stale), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
